// File: rtl/text_grid_pkg.sv
// text_grid_pkg: shared types, constants, palette and procedural glyph ROM for the text grid renderer.
package text_grid_pkg;
  typedef struct packed {
    logic [3:0] bg;
    logic [3:0] fg;
    logic [7:0] code;
  } cell_t;
  typedef enum logic {IDLE, CLEAR} wr_state_e;
  typedef enum logic [1:0] {SC_NONE, SC_UP, SC_DOWN} scroll_e;
  localparam logic [15:0] BLANK_CELL = 16'h0F20;
  localparam int DISPLAY_LATENCY = 6;
  // Entry 0 is near-black so grid cells stay distinguishable from the blanked border.
  localparam logic [23:0] PALETTE [16] = '{
    24'h101010, 24'h0000AA, 24'h00AA00, 24'h00AAAA, 24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF, 24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };
  // 'A' is an outlined box with a crossbar; 0 and space are blank; other codes draw an underline.
  function automatic logic glyph_bit(input logic [7:0] code, input int row, input int col, input int gw, input int gh);
    int mx, my;
    logic box;
    mx = gw / 8;
    my = gh / 8;
    box = row >= my && row <= gh - 1 - my && col >= mx && col <= gw - 1 - mx;
    return code == 8'h41 ? box && (col == mx || col == gw - 1 - mx || row == my || row == gh / 2)
         : code == 8'h00 || code == 8'h20 ? 1'b0 : row == gh - 1;
  endfunction
endpackage

// File: rtl/text_grid_write_ctrl.sv
// text_grid_write_ctrl: cell-buffer port B owner; arbitrates host writes against the clear sweep.
module text_grid_write_ctrl
  import text_grid_pkg::*;
#(
  parameter int DEPTH = 19456,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic          clear_req,
  output logic          wr_ready,
  output logic          clear_busy,
  output logic          b_we,
  output logic [AW-1:0] b_addr,
  output logic [15:0]   b_data
);
  wr_state_e state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  always_comb begin
    wr_ready = state_q == IDLE;
    clear_busy = state_q == CLEAR;
    b_we = clear_busy || (wr_valid && wr_ready && 32'(wr_addr) < DEPTH);
    b_addr = clear_busy ? cnt_q : wr_addr;
    b_data = clear_busy ? BLANK_CELL : wr_data;
    state_d = state_q == IDLE ? (clear_req ? CLEAR : IDLE) : (32'(cnt_q) == DEPTH - 1 ? IDLE : CLEAR);
    cnt_d = clear_busy ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/text_grid_renderer.sv
// text_grid_renderer: 6-cycle text-mode pixel pipeline with scrollback, write port and clear sweep.
// Optional blinking cursor (fg/bg swap) when TEXT_GRID_CURSOR_EN is defined.
module text_grid_renderer
  import text_grid_pkg::*;
#(
  parameter int GLYPH_W    = 16,
  parameter int GLYPH_H    = 16,
  parameter int COLS       = 76,
  parameter int ROWS       = 42,
  parameter int BUF_ROWS   = 256,
  parameter int NUM_GLYPHS = 128
`ifdef TEXT_GRID_CURSOR_EN
  , parameter int BLINK_FRAMES = 30
`endif
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  input  logic                              scroll_up,
  input  logic                              scroll_down,
`ifdef TEXT_GRID_CURSOR_EN
  input  logic [$clog2(COLS)-1:0]           cursor_col,
  input  logic [$clog2(ROWS)-1:0]           cursor_row,
`endif
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [$clog2(BUF_ROWS*COLS)-1:0]  wr_addr,
  input  logic [15:0]                       wr_data,
  input  logic                              clear_req,
  output logic                              clear_busy,
  output logic [$clog2(BUF_ROWS)-1:0]       scroll_offset,
  output logic [7:0]                        red_out,
  output logic [7:0]                        green_out,
  output logic [7:0]                        blue_out
);
  localparam int DEPTH = BUF_ROWS * COLS;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(BUF_ROWS);
  localparam int GX = $clog2(GLYPH_W);
  localparam int GY = $clog2(GLYPH_H);
  localparam logic [RW-1:0] MAX_OFF = RW'(BUF_ROWS - ROWS);
  typedef struct packed {
    logic          vld;
    logic          grid;
    logic          swap;
    logic [GX-1:0] gx;
    logic [GY-1:0] gy;
  } side_t;
  side_t side_d, side_q [DISPLAY_LATENCY-1];
  logic [AW-1:0] addr_d, addr_q, b_addr;
  logic [15:0] mem [DEPTH];
  logic [15:0] b_data;
  cell_t raw_q, cell_q;
  logic [GLYPH_W-1:0] glyph_d, glyph_raw_q, glyph_q;
  logic [7:0] pair_d, pair1_q, pair2_q, code_idx;
  logic [23:0] rgb_d, rgb_q;
  logic [31:0] row_sum;
  scroll_e pend_d, pend_q;
  logic [RW-1:0] off_d, off_q;
  logic frame_start, in_grid, swap, b_we;

  text_grid_write_ctrl #(.DEPTH(DEPTH)) u_wr (
    .clk(pixel_clk_in), .rst(rst_in), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .wr_ready(wr_ready), .clear_busy(clear_busy),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data)
  );

`ifdef TEXT_GRID_CURSOR_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_d, blink_cnt_q;
  logic blink_d, blink_q;
  // Counter counts frame starts; the phase flips on the start of every BLINK_FRAMES-th following frame.
  always_comb begin
    swap = blink_q && 32'(hcount_in >> GX) == 32'(cursor_col) && 32'(vcount_in >> GY) == 32'(cursor_row);
    blink_cnt_d = !frame_start ? blink_cnt_q : 32'(blink_cnt_q) == BLINK_FRAMES ? BW'(1) : blink_cnt_q + 1'b1;
    blink_d = frame_start && 32'(blink_cnt_q) == BLINK_FRAMES ? !blink_q : blink_q;
  end
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      blink_cnt_q <= '0;
      blink_q <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
    end
  end
`else
  assign swap = 1'b0;
`endif

  always_comb begin
    frame_start = hcount_in == '0 && vcount_in == '0;
    in_grid = 32'(hcount_in) < COLS * GLYPH_W && 32'(vcount_in) < ROWS * GLYPH_H;
    row_sum = 32'(vcount_in >> GY) + 32'(off_q);
    addr_d = in_grid ? AW'(row_sum * COLS + 32'(hcount_in >> GX)) : '0;
    side_d = '{vld: 1'b1, grid: in_grid, swap: swap, gx: hcount_in[GX-1:0], gy: vcount_in[GY-1:0]};
    pend_d = scroll_up && !scroll_down ? SC_UP : scroll_down && !scroll_up ? SC_DOWN
           : frame_start ? SC_NONE : pend_q;
    off_d = !frame_start ? off_q
          : pend_q == SC_UP && off_q < MAX_OFF ? off_q + 1'b1
          : pend_q == SC_DOWN && off_q != '0 ? off_q - 1'b1 : off_q;
    code_idx = 32'(cell_q.code) < NUM_GLYPHS ? cell_q.code : 8'h00;
    for (int c = 0; c < GLYPH_W; c++)
      glyph_d[c] = glyph_bit(code_idx, int'(side_q[2].gy), c, GLYPH_W, GLYPH_H);
    pair_d = side_q[2].swap ? {cell_q.bg, cell_q.fg} : {cell_q.fg, cell_q.bg};
    rgb_d = side_q[DISPLAY_LATENCY-2].vld && side_q[DISPLAY_LATENCY-2].grid
          ? PALETTE[glyph_q[side_q[DISPLAY_LATENCY-2].gx] ? pair2_q[7:4] : pair2_q[3:0]] : '0;
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DISPLAY_LATENCY - 1; i++) side_q[i] <= '0;
      rgb_q <= '0;
      pend_q <= SC_NONE;
      off_q <= '0;
    end else begin
      side_q[0] <= side_d;
      for (int i = 1; i < DISPLAY_LATENCY - 1; i++) side_q[i] <= side_q[i-1];
      rgb_q <= rgb_d;
      pend_q <= pend_d;
      off_q <= off_d;
    end
  end

  // Port B writes and port A display reads share the array; a same-cycle collision returns old data.
  always_ff @(posedge pixel_clk_in) begin
    if (b_we) mem[b_addr] <= b_data;
    addr_q <= addr_d;
    raw_q <= mem[addr_q];
    cell_q <= raw_q;
    glyph_raw_q <= glyph_d;
    glyph_q <= glyph_raw_q;
    pair1_q <= pair_d;
    pair2_q <= pair1_q;
  end

  assign {red_out, green_out, blue_out} = rgb_q;
  assign scroll_offset = off_q;
endmodule
